perip_wb_decoder: RTL and testbench
===================================

# perip_wb_decoder

Single-master to multi-slave Wishbone classic decoder that sits directly upstream of the peripheral slaves: the core's data-side Wishbone port feeds it, and it drives the CLINT (slave 0) and the other memory-mapped peripherals. It registers each request, decodes the address against per-slave base/mask pairs, and forwards one transaction at a time. It returns the selected slave's data and ack, or a Wishbone error for unmapped addresses and slaves that hang.

## Interface
- `AW`, 32: address width (matches `WB_AD_WIDTH`).
- `DW`, 32: data width (matches `WB_DAT_WIDTH`).
- `NSLV`, 4: number of slaves.
- `SLV_BASE`, {0x0300_0000, 0x1000_1000, 0x1000_0000, 0x0200_0000}: flattened NSLV*AW; slot i at [i*AW +: AW].
- `SLV_MASK`, {0xFFFF_F000, 0xFFFF_F000, 0xFFFF_F000, 0xFFFF_0000}: flattened NSLV*AW; slave i hit when (addr & mask_i) == base_i.
- `RDATA_EARLY`, 4'b0001: per-slave bit. When set, read data is valid in the cycle before that slave's ack (CLINT behaviour).
- `TMO_CYCLES`, 255: maximum cycles a slave strobe stays asserted without ack; range 2..65535.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wbm_cyc_i`, `wbm_stb_i`, `wbm_we_i`  in  1 each  master request.
- `wbm_addr_i`  in  AW  master address.
- `wbm_wdata_i`  in  DW  master write data.
- `wbm_sel_i`  in  DW/8  master byte select.
- `wbm_rdata_o`  out  DW  read data; valid only with ack, otherwise 0.
- `wbm_ack_o`  out  1  one-cycle completion.
- `wbm_err_o`  out  1  one-cycle error completion.
- `slv_cyc_o`, `slv_stb_o`  out  NSLV  one-hot per-slave cycle and strobe.
- `slv_addr_o`  out  AW  shared latched address.
- `slv_wdata_o`  out  DW  shared latched write data.
- `slv_sel_o`  out  DW/8  shared latched byte select.
- `slv_we_o`  out  1  shared latched write enable.
- `slv_rdata_i`  in  NSLV*DW  flattened slave read data.
- `slv_ack_i`  in  NSLV  slave acks.

## Operation
The FSM has four states.

- **IDLE**
  - Condition: `wbm_cyc_i & wbm_stb_i`.
  - Latch addr, wdata, sel and we into registers.
  - Decode the address. If several slaves match, the lowest index wins.
  - Hit: store the index, clear the timeout counter, go to ACTIVE.
  - No hit: go to ERR.
- **ACTIVE**
  - Drive `slv_cyc_o[idx]` and `slv_stb_o[idx]` high; all other slave bits stay 0.
  - Read-data capture register:
    - If `RDATA_EARLY[idx]` is set, load `slv_rdata_i[idx]` every ACTIVE cycle while `slv_ack_i[idx]` is 0, and freeze it in the cycle ack is seen.
    - Otherwise, load `slv_rdata_i[idx]` in the ack cycle.
  - `slv_ack_i[idx]` = 1: go to RESP.
  - Otherwise, if counter == TMO_CYCLES-1: go to ERR. If not, increment the counter.
  - An ack in the same cycle as timeout wins (go to RESP).
  - Acks from non-selected slaves are ignored.
  - `wbm_cyc_i` = 0 (master abort): go to IDLE. No ack, no err.
- **RESP**
  - `wbm_ack_o` = 1.
  - `wbm_rdata_o` = captured data for reads, 0 for writes.
  - Slave strobes are low.
  - Next state: IDLE.
- **ERR**
  - `wbm_err_o` = 1, `wbm_rdata_o` = 0, slave strobes low.
  - Next state: IDLE.

Ack and err are never asserted in the same cycle. The slave side has at most one transaction outstanding.

## Timing
- **Reset values:** state IDLE. All outputs 0, including the `slv_*` shared buses, which are cleared with the latch registers. Reset mid-transaction drops slave strobes in the next cycle; no ack or err is produced.
- **Hit latency:** request seen in IDLE at cycle 0 → slave strobe from cycle 1 → slave ack at cycle k ≥ 1 → `wbm_ack_o` at k+1. Slave strobe falls at k+1.
  - For a slave with a registered ack (CLINT), ack arrives at 2 and the master ack at 3.
- **Unmapped address:** `wbm_err_o` at cycle 1.
- **Timeout:** the strobe is high for exactly TMO_CYCLES cycles, then `wbm_err_o` is asserted in the following cycle.
- **Back-to-back:** the master holds stb until ack/err. A new request seen in the cycle after RESP/ERR is accepted. Minimum spacing is 3 cycles per transaction.
- Slave inputs are sampled only in ACTIVE. Master inputs are sampled only in IDLE; changes during ACTIVE are ignored, except `wbm_cyc_i` dropping (abort).

## Test plan
- **CLINT read:** read 0x0200_4000; the slave 0 model returns 0xDEAD_BEEF combinationally before its registered ack and 0 in the ack cycle → `wbm_ack_o` at cycle 3 with `wbm_rdata_o` = 0xDEAD_BEEF; `slv_stb_o` = 4'b0001 during cycles 1–2 only.
- **Write to slave 2:** write 0x1000_1004, data 0x1234_5678, sel 4'hF → `slv_stb_o` = 4'b0100 and `slv_wdata_o` = 0x1234_5678 from cycle 1; slave acks at cycle 4 → `wbm_ack_o` at cycle 5 with `wbm_rdata_o` = 0.
- **Unmapped:** access 0x8000_0000 → `wbm_err_o` = 1 at cycle 1, `slv_stb_o` never asserted, `wbm_ack_o` stays 0.
- **Timeout:** TMO_CYCLES = 4, slave 1 never acks → strobe high in cycles 1–4, `wbm_err_o` at cycle 5.
  - Repeat with the ack arriving at cycle 4 → `wbm_ack_o` at cycle 5, no err.
- **Abort and reset:** master drops cyc at cycle 2 → slave strobe low at cycle 3, no ack/err, FSM back in IDLE.
  - Assert `rst` during ACTIVE → all outputs 0 in the next cycle.
  - A fresh read issued after either case completes normally.
- **Overlap priority:** set slave 3's base to overlap slave 0, then access the overlapping address → only `slv_stb_o[0]` is asserted.

Source files
------------

// File: rtl/perip_wb_decoder_if.sv
// Bus bundle between the core's data-side Wishbone port, the decoder and the peripheral slaves.
// The decoder uses the slave modport; the driving environment uses the master modport.
interface perip_wb_decoder_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int NSLV = 4
);
  logic                 wbm_cyc_i;
  logic                 wbm_stb_i;
  logic                 wbm_we_i;
  logic [AW-1:0]        wbm_addr_i;
  logic [DW-1:0]        wbm_wdata_i;
  logic [DW/8-1:0]      wbm_sel_i;
  logic [DW-1:0]        wbm_rdata_o;
  logic                 wbm_ack_o;
  logic                 wbm_err_o;

  logic [NSLV-1:0]      slv_cyc_o;
  logic [NSLV-1:0]      slv_stb_o;
  logic [AW-1:0]        slv_addr_o;
  logic [DW-1:0]        slv_wdata_o;
  logic [DW/8-1:0]      slv_sel_o;
  logic                 slv_we_o;
  logic [NSLV*DW-1:0]   slv_rdata_i;
  logic [NSLV-1:0]      slv_ack_i;

  modport slave (
    input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_addr_i, wbm_wdata_i, wbm_sel_i,
    input  slv_rdata_i, slv_ack_i,
    output wbm_rdata_o, wbm_ack_o, wbm_err_o,
    output slv_cyc_o, slv_stb_o, slv_addr_o, slv_wdata_o, slv_sel_o, slv_we_o
  );

  modport master (
    output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_addr_i, wbm_wdata_i, wbm_sel_i,
    output slv_rdata_i, slv_ack_i,
    input  wbm_rdata_o, wbm_ack_o, wbm_err_o,
    input  slv_cyc_o, slv_stb_o, slv_addr_o, slv_wdata_o, slv_sel_o, slv_we_o
  );
endinterface

// File: rtl/perip_wb_decoder.sv
// Single-master to multi-slave Wishbone classic decoder: registers one request, routes it to the
// first matching slave, and returns its ack/data, or err on an unmapped address or a hung slave.
module perip_wb_decoder #(
  parameter int                 AW          = 32,
  parameter int                 DW          = 32,
  parameter int                 NSLV        = 4,
  parameter logic [NSLV*AW-1:0] SLV_BASE    = {32'h0300_0000, 32'h1000_1000, 32'h1000_0000, 32'h0200_0000},
  parameter logic [NSLV*AW-1:0] SLV_MASK    = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000},
  parameter logic [NSLV-1:0]    RDATA_EARLY = 4'b0001,
  parameter int                 TMO_CYCLES  = 255
) (
  input  logic               clk,
  input  logic               rst,
  perip_wb_decoder_if.slave  bus
);

  localparam int          IDXW     = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_RESP, ST_ERR} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic            we_q, we_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  // Address decode; scanning downwards lets the lowest matching index win.
  logic            hit;
  logic [IDXW-1:0] hit_idx;
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((bus.wbm_addr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit     = 1'b1;
        hit_idx = IDXW'(i);
      end
    end
  end

  logic            cur_ack;
  logic            cur_early;
  logic [DW-1:0]   cur_rdata;
  always_comb begin
    cur_ack   = 1'b0;
    cur_early = 1'b0;
    cur_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == IDXW'(i)) begin
        cur_ack   = bus.slv_ack_i[i];
        cur_early = RDATA_EARLY[i];
        cur_rdata = bus.slv_rdata_i[i*DW +: DW];
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    we_d    = we_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
          addr_d  = bus.wbm_addr_i;
          wdata_d = bus.wbm_wdata_i;
          sel_d   = bus.wbm_sel_i;
          we_d    = bus.wbm_we_i;
          idx_d   = hit_idx;
          cnt_d   = '0;
          state_d = hit ? ST_ACTIVE : ST_ERR;
        end
      end
      ST_ACTIVE: begin
        // Early slaves present data before ack and may drop it in the ack cycle.
        if (cur_early && !cur_ack) rdata_d = cur_rdata;
        if (!cur_early && cur_ack) rdata_d = cur_rdata;
        if (!bus.wbm_cyc_i)           state_d = ST_IDLE;
        else if (cur_ack)             state_d = ST_RESP;
        else if (cnt_q == TMO_LAST)   state_d = ST_ERR;
        else                          cnt_d   = cnt_q + 16'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: synchronous reset clears the latch registers too, so the shared slave buses read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  logic [NSLV-1:0] onehot;
  assign onehot = NSLV'(1) << idx_q;

  assign bus.slv_cyc_o   = (state_q == ST_ACTIVE) ? onehot : '0;
  assign bus.slv_stb_o   = (state_q == ST_ACTIVE) ? onehot : '0;
  assign bus.slv_addr_o  = addr_q;
  assign bus.slv_wdata_o = wdata_q;
  assign bus.slv_sel_o   = sel_q;
  assign bus.slv_we_o    = we_q;
  assign bus.wbm_ack_o   = (state_q == ST_RESP);
  assign bus.wbm_err_o   = (state_q == ST_ERR);
  assign bus.wbm_rdata_o = (state_q == ST_RESP && !we_q) ? rdata_q : '0;

endmodule

// File: tb/tb_perip_wb_decoder.sv
// Directed bench for perip_wb_decoder: CLINT read, writes, unmapped, timeout, abort, reset, overlap.
module tb_perip_wb_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perip_wb_decoder_if #(.AW(32), .DW(32), .NSLV(4)) bus ();
  perip_wb_decoder_if #(.AW(32), .DW(32), .NSLV(4)) obus ();

  perip_wb_decoder #(.TMO_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  perip_wb_decoder #(
    .SLV_BASE({32'h0200_0000, 32'h1000_1000, 32'h1000_0000, 32'h0200_0000}),
    .RDATA_EARLY(4'b0000),
    .TMO_CYCLES(4)
  ) dut_ovl (.clk(clk), .rst(rst), .bus(obus));

  // Slave models: slave 0 behaves like the CLINT (registered ack, data only before ack).
  logic        clint_ack;
  logic        ack1, ack2, ack3;
  logic [31:0] rd1, rd2, rd3, rd0;
  logic        o_ack0;
  logic [31:0] o_rd0;

  always @(posedge clk) begin
    if (rst) clint_ack <= 1'b0;
    else     clint_ack <= bus.slv_stb_o[0] & ~clint_ack;
  end
  assign rd0             = (bus.slv_stb_o[0] && !clint_ack) ? 32'hDEAD_BEEF : 32'h0;
  assign bus.slv_rdata_i = {rd3, rd2, rd1, rd0};
  assign bus.slv_ack_i   = {ack3, ack2, ack1, clint_ack};
  assign obus.slv_rdata_i = {96'h0, o_rd0};
  assign obus.slv_ack_i   = {3'b000, o_ack0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_we_i = we;
    bus.wbm_addr_i = a; bus.wbm_wdata_i = d; bus.wbm_sel_i = s;
  endtask

  task automatic idle_master();
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; bus.wbm_we_i = 1'b0;
    bus.wbm_addr_i = '0; bus.wbm_wdata_i = '0; bus.wbm_sel_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.slv_stb_o !== 4'b0000 || bus.slv_cyc_o !== 4'b0000) begin failures++; $display("FAIL reset_strobes stb=%b cyc=%b exp=0000", bus.slv_stb_o, bus.slv_cyc_o); end
    checks++; if (bus.wbm_ack_o !== 1'b0 || bus.wbm_err_o !== 1'b0) begin failures++; $display("FAIL reset_ack_err ack=%b err=%b exp=0", bus.wbm_ack_o, bus.wbm_err_o); end
    checks++; if (bus.wbm_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.wbm_rdata_o); end
    checks++; if ({bus.slv_addr_o, bus.slv_wdata_o, bus.slv_sel_o, bus.slv_we_o} !== 69'h0) begin failures++; $display("FAIL reset_shared addr=%h wdata=%h sel=%h we=%b exp=0", bus.slv_addr_o, bus.slv_wdata_o, bus.slv_sel_o, bus.slv_we_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clint_read(input string tag);
    req(1'b0, 32'h0200_4000, 32'h0, 4'hF);
    tick();
    checks++; if (bus.slv_stb_o !== 4'b0001 || bus.slv_cyc_o !== 4'b0001) begin failures++; $display("FAIL %s_stb_c1 stb=%b cyc=%b exp=0001", tag, bus.slv_stb_o, bus.slv_cyc_o); end
    checks++; if (bus.slv_addr_o !== 32'h0200_4000 || bus.slv_we_o !== 1'b0) begin failures++; $display("FAIL %s_addr got=%h we=%b exp=02004000 we=0", tag, bus.slv_addr_o, bus.slv_we_o); end
    tick();
    checks++; if (bus.slv_stb_o !== 4'b0001 || bus.wbm_ack_o !== 1'b0) begin failures++; $display("FAIL %s_c2 stb=%b ack=%b exp=0001 ack=0", tag, bus.slv_stb_o, bus.wbm_ack_o); end
    tick();
    checks++; if (bus.wbm_ack_o !== 1'b1 || bus.wbm_err_o !== 1'b0) begin failures++; $display("FAIL %s_ack_c3 ack=%b err=%b exp=1/0", tag, bus.wbm_ack_o, bus.wbm_err_o); end
    checks++; if (bus.wbm_rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL %s_rdata got=%h exp=deadbeef", tag, bus.wbm_rdata_o); end
    checks++; if (bus.slv_stb_o !== 4'b0000) begin failures++; $display("FAIL %s_stb_c3 got=%b exp=0000", tag, bus.slv_stb_o); end
    idle_master();
    tick();
    checks++; if (bus.wbm_ack_o !== 1'b0 || bus.wbm_rdata_o !== 32'h0) begin failures++; $display("FAIL %s_after ack=%b rdata=%h exp=0", tag, bus.wbm_ack_o, bus.wbm_rdata_o); end
  endtask

  task automatic test_write();
    req(1'b1, 32'h1000_1004, 32'h1234_5678, 4'hF);
    tick();
    checks++; if (bus.slv_stb_o !== 4'b0100) begin failures++; $display("FAIL wr_stb_c1 got=%b exp=0100", bus.slv_stb_o); end
    checks++; if (bus.slv_wdata_o !== 32'h1234_5678 || bus.slv_sel_o !== 4'hF || bus.slv_we_o !== 1'b1) begin failures++; $display("FAIL wr_shared wdata=%h sel=%h we=%b exp=12345678 f 1", bus.slv_wdata_o, bus.slv_sel_o, bus.slv_we_o); end
    tick(); tick(); tick();
    checks++; if (bus.slv_stb_o !== 4'b0100 || bus.wbm_err_o !== 1'b0) begin failures++; $display("FAIL wr_stb_c4 stb=%b err=%b exp=0100 err=0", bus.slv_stb_o, bus.wbm_err_o); end
    ack2 = 1'b1; rd2 = 32'h5555_AAAA;
    tick();
    ack2 = 1'b0; rd2 = 32'h0;
    checks++; if (bus.wbm_ack_o !== 1'b1 || bus.wbm_err_o !== 1'b0) begin failures++; $display("FAIL wr_ack_c5 ack=%b err=%b exp=1/0", bus.wbm_ack_o, bus.wbm_err_o); end
    checks++; if (bus.wbm_rdata_o !== 32'h0 || bus.slv_stb_o !== 4'b0000) begin failures++; $display("FAIL wr_resp rdata=%h stb=%b exp=0/0000", bus.wbm_rdata_o, bus.slv_stb_o); end
    idle_master();
    tick();
  endtask

  task automatic test_unmapped();
    req(1'b0, 32'h8000_0000, 32'h0, 4'hF);
    tick();
    checks++; if (bus.wbm_err_o !== 1'b1 || bus.wbm_ack_o !== 1'b0) begin failures++; $display("FAIL unm_c1 err=%b ack=%b exp=1/0", bus.wbm_err_o, bus.wbm_ack_o); end
    checks++; if (bus.slv_stb_o !== 4'b0000 || bus.wbm_rdata_o !== 32'h0) begin failures++; $display("FAIL unm_stb stb=%b rdata=%h exp=0", bus.slv_stb_o, bus.wbm_rdata_o); end
    idle_master();
    tick();
    checks++; if (bus.wbm_err_o !== 1'b0 || bus.slv_stb_o !== 4'b0000) begin failures++; $display("FAIL unm_c2 err=%b stb=%b exp=0", bus.wbm_err_o, bus.slv_stb_o); end
  endtask

  task automatic test_timeout(input logic ack_late);
    req(1'b0, 32'h1000_0010, 32'h0, 4'hF);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (bus.slv_stb_o !== 4'b0010 || bus.wbm_err_o !== 1'b0) begin failures++; $display("FAIL tmo%0d_c%0d stb=%b err=%b exp=0010 err=0", ack_late, c, bus.slv_stb_o, bus.wbm_err_o); end
    end
    if (ack_late) begin ack1 = 1'b1; rd1 = 32'h0BAD_F00D; end
    tick();
    ack1 = 1'b0; rd1 = 32'h0;
    checks++; if (bus.wbm_err_o !== !ack_late || bus.wbm_ack_o !== ack_late) begin failures++; $display("FAIL tmo%0d_c5 err=%b ack=%b exp err=%b ack=%b", ack_late, bus.wbm_err_o, bus.wbm_ack_o, !ack_late, ack_late); end
    checks++; if (bus.wbm_rdata_o !== (ack_late ? 32'h0BAD_F00D : 32'h0) || bus.slv_stb_o !== 4'b0000) begin failures++; $display("FAIL tmo%0d_rdata rdata=%h stb=%b", ack_late, bus.wbm_rdata_o, bus.slv_stb_o); end
    idle_master();
    tick();
  endtask

  task automatic test_abort();
    req(1'b0, 32'h1000_0020, 32'h0, 4'hF);
    tick();
    checks++; if (bus.slv_stb_o !== 4'b0010) begin failures++; $display("FAIL abort_c1 stb=%b exp=0010", bus.slv_stb_o); end
    tick();
    bus.wbm_cyc_i = 1'b0;
    tick();
    checks++; if (bus.slv_stb_o !== 4'b0000 || bus.slv_cyc_o !== 4'b0000) begin failures++; $display("FAIL abort_c3 stb=%b cyc=%b exp=0000", bus.slv_stb_o, bus.slv_cyc_o); end
    checks++; if (bus.wbm_ack_o !== 1'b0 || bus.wbm_err_o !== 1'b0) begin failures++; $display("FAIL abort_resp ack=%b err=%b exp=0", bus.wbm_ack_o, bus.wbm_err_o); end
    idle_master();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus.wbm_ack_o !== 1'b0 || bus.wbm_err_o !== 1'b0 || bus.slv_stb_o !== 4'b0000) begin failures++; $display("FAIL abort_quiet%0d ack=%b err=%b stb=%b", c, bus.wbm_ack_o, bus.wbm_err_o, bus.slv_stb_o); end
    end
    test_clint_read("post_abort");
  endtask

  task automatic test_reset_mid();
    req(1'b1, 32'h1000_1008, 32'hA5A5_0001, 4'h3);
    tick();
    checks++; if (bus.slv_stb_o !== 4'b0100) begin failures++; $display("FAIL rstmid_c1 stb=%b exp=0100", bus.slv_stb_o); end
    rst = 1'b1;
    tick();
    checks++; if (bus.slv_stb_o !== 4'b0000 || bus.slv_cyc_o !== 4'b0000 || bus.wbm_ack_o !== 1'b0 || bus.wbm_err_o !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl stb=%b cyc=%b ack=%b err=%b exp=0", bus.slv_stb_o, bus.slv_cyc_o, bus.wbm_ack_o, bus.wbm_err_o); end
    checks++; if ({bus.slv_addr_o, bus.slv_wdata_o, bus.slv_sel_o, bus.slv_we_o} !== 69'h0 || bus.wbm_rdata_o !== 32'h0) begin failures++; $display("FAIL rstmid_shared addr=%h wdata=%h sel=%h we=%b exp=0", bus.slv_addr_o, bus.slv_wdata_o, bus.slv_sel_o, bus.slv_we_o); end
    rst = 1'b0;
    idle_master();
    tick();
    test_clint_read("post_reset");
  endtask

  task automatic test_slave3_read();
    req(1'b0, 32'h0300_0010, 32'h0, 4'hF);
    rd3 = 32'h1111_1111;
    tick();
    checks++; if (bus.slv_stb_o !== 4'b1000) begin failures++; $display("FAIL s3_c1 stb=%b exp=1000", bus.slv_stb_o); end
    ack3 = 1'b1; rd3 = 32'hCAFE_0003;
    tick();
    ack3 = 1'b0; rd3 = 32'h0;
    checks++; if (bus.wbm_ack_o !== 1'b1 || bus.wbm_rdata_o !== 32'hCAFE_0003) begin failures++; $display("FAIL s3_resp ack=%b rdata=%h exp=1 cafe0003", bus.wbm_ack_o, bus.wbm_rdata_o); end
    idle_master();
    tick();
  endtask

  task automatic test_back_to_back();
    req(1'b0, 32'h8000_0000, 32'h0, 4'hF);
    tick();
    checks++; if (bus.wbm_err_o !== 1'b1) begin failures++; $display("FAIL b2b_err got=%b exp=1", bus.wbm_err_o); end
    req(1'b0, 32'h0200_0008, 32'h0, 4'hF);
    tick();
    checks++; if (bus.slv_stb_o !== 4'b0000 || bus.wbm_err_o !== 1'b0) begin failures++; $display("FAIL b2b_idle stb=%b err=%b exp=0", bus.slv_stb_o, bus.wbm_err_o); end
    tick();
    checks++; if (bus.slv_stb_o !== 4'b0001 || bus.slv_addr_o !== 32'h0200_0008) begin failures++; $display("FAIL b2b_active stb=%b addr=%h exp=0001 02000008", bus.slv_stb_o, bus.slv_addr_o); end
    tick(); tick();
    checks++; if (bus.wbm_ack_o !== 1'b1 || bus.wbm_rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_ack ack=%b rdata=%h exp=1 deadbeef", bus.wbm_ack_o, bus.wbm_rdata_o); end
    idle_master();
    tick();
  endtask

  task automatic test_overlap();
    obus.wbm_cyc_i = 1'b1; obus.wbm_stb_i = 1'b1; obus.wbm_we_i = 1'b0;
    obus.wbm_addr_i = 32'h0200_0004; obus.wbm_wdata_i = '0; obus.wbm_sel_i = 4'hF;
    tick();
    checks++; if (obus.slv_stb_o !== 4'b0001) begin failures++; $display("FAIL ovl_stb got=%b exp=0001", obus.slv_stb_o); end
    o_ack0 = 1'b1; o_rd0 = 32'h00C0_FFEE;
    tick();
    o_ack0 = 1'b0; o_rd0 = 32'h0;
    checks++; if (obus.wbm_ack_o !== 1'b1 || obus.wbm_rdata_o !== 32'h00C0_FFEE) begin failures++; $display("FAIL ovl_resp ack=%b rdata=%h exp=1 00c0ffee", obus.wbm_ack_o, obus.wbm_rdata_o); end
    obus.wbm_cyc_i = 1'b0; obus.wbm_stb_i = 1'b0;
    tick();
  endtask

  initial begin
    idle_master();
    obus.wbm_cyc_i = 1'b0; obus.wbm_stb_i = 1'b0; obus.wbm_we_i = 1'b0;
    obus.wbm_addr_i = '0; obus.wbm_wdata_i = '0; obus.wbm_sel_i = '0;
    ack1 = 1'b0; ack2 = 1'b0; ack3 = 1'b0;
    rd1 = '0; rd2 = '0; rd3 = '0;
    o_ack0 = 1'b0; o_rd0 = '0;

    test_reset();
    test_clint_read("clint");
    test_write();
    test_unmapped();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_abort();
    test_reset_mid();
    test_slave3_read();
    test_back_to_back();
    test_overlap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
